// File: rtl/alu_issue_ctrl.sv
// Decode/issue controller for the combinational ALU: accept, regfile read, execute, writeback.
// Optional perf counters are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_ctrl #(
  parameter logic [4:0]  RSTATUS_REG = 5'd30,
  parameter int unsigned IMM_W       = 17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_ovf,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [15:0] perf_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state, state_nx;
  logic [31:0] insn_q;
  logic [1:0]  ovf_code_q;
  logic [1:0]  ovf_code;
  logic [4:0]  op, aluop, rd;
  logic        is_r, is_addi, legal, ovf_hit, rd_nz;
  logic [31:0] imm_ext;

  assign op      = insn_q[31:27];
  assign rd      = insn_q[26:22];
  assign aluop   = insn_q[6:2];
  assign is_r    = (op == 5'b00000) && (aluop <= 5'd5);
  assign is_addi = (op == 5'b00101);
  assign legal   = is_r || is_addi;
  assign rd_nz   = (rd != 5'd0);
  assign imm_ext = {{(32 - IMM_W){insn_q[IMM_W-1]}}, insn_q[IMM_W-1:0]};

  // Overflow tag: 1 add, 2 addi, 3 sub; 0 means the op never reports overflow.
  always_comb begin
    ovf_code = 2'd0;
    if (is_addi)
      ovf_code = 2'd2;
    else if (is_r && aluop == 5'd0)
      ovf_code = 2'd1;
    else if (is_r && aluop == 5'd1)
      ovf_code = 2'd3;
  end

  assign ovf_hit = alu_ovf && (ovf_code_q != 2'd0);

  // Addresses come straight from the incoming word on the accept cycle so the
  // registered regfile read lands in READ; afterwards they hold the latched word.
  assign rf_rs_addr = (state == IDLE && in_valid) ? in_insn[21:17] : insn_q[21:17];
  assign rf_rt_addr = (state == IDLE && in_valid) ? in_insn[16:12] : insn_q[16:12];

  assign in_ready = (state == IDLE);
  assign wb_valid = (state == WB);
  assign illegal  = (state == READ) && !legal;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = READ;
      READ: state_nx = legal ? EXEC : IDLE;
      EXEC: state_nx = (ovf_hit || rd_nz) ? WB : IDLE;
      WB:   if (wb_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      insn_q     <= '0;
      alu_opA    <= '0;
      alu_opB    <= '0;
      alu_opcode <= '0;
      alu_shamt  <= '0;
      ovf_code_q <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) insn_q <= in_insn;
        READ: if (legal) begin
          alu_opA    <= rf_rs_data;
          alu_opB    <= is_addi ? imm_ext : rf_rt_data;
          alu_opcode <= is_addi ? 5'd0 : aluop;
          alu_shamt  <= is_addi ? 5'd0 : insn_q[11:7];
          ovf_code_q <= ovf_code;
        end
        EXEC: begin
          if (ovf_hit) begin
            wb_rd   <= RSTATUS_REG;
            wb_data <= {30'd0, ovf_code_q};
          end else if (rd_nz) begin
            wb_rd   <= rd;
            wb_data <= alu_result;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic wb_ovf_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_retired <= '0;
      perf_ovf     <= '0;
      wb_ovf_q     <= 1'b0;
    end else begin
      if (state == EXEC)
        wb_ovf_q <= ovf_hit;
      if ((state == WB && wb_ready) || (state == EXEC && !ovf_hit && !rd_nz))
        perf_retired <= perf_retired + 32'd1;
      if (state == WB && wb_ready && wb_ovf_q)
        perf_ovf <= perf_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered-read regfile and a behavioural ALU.
module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [4:0]  rf_rs_addr, rf_rt_addr;
  logic [31:0] rf_rs_data, rf_rt_data;
  logic [31:0] alu_opA, alu_opB;
  logic [4:0]  alu_opcode, alu_shamt;
  logic [31:0] alu_result;
  logic        alu_ovf;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  logic [31:0] regs [32];

  alu_issue_ctrl #(.RSTATUS_REG(5'd30), .IMM_W(17)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_ovf(alu_ovf),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rf_rs_data <= regs[rf_rs_addr];
    rf_rt_data <= regs[rf_rt_addr];
  end

  // Environment ALU: overflow only reported for add/sub.
  always @* begin
    alu_ovf    = 1'b0;
    alu_result = 32'd0;
    case (alu_opcode)
      5'd0: begin
        alu_result = alu_opA + alu_opB;
        alu_ovf = (alu_opA[31] == alu_opB[31]) && (alu_result[31] != alu_opA[31]);
      end
      5'd1: begin
        alu_result = alu_opA - alu_opB;
        alu_ovf = (alu_opA[31] != alu_opB[31]) && (alu_result[31] != alu_opA[31]);
      end
      5'd2: alu_result = alu_opA & alu_opB;
      5'd3: alu_result = alu_opA | alu_opB;
      5'd4: alu_result = alu_opA << alu_shamt;
      5'd5: alu_result = $unsigned($signed(alu_opA) >>> alu_shamt);
      default: alu_result = 32'd0;
    endcase
  end

  function automatic logic [31:0] r_insn(input logic [4:0] rd, rs, rt, sh, aop);
    return {5'b00000, rd, rs, rt, sh, aop, 2'b00};
  endfunction

  function automatic logic [31:0] addi_insn(input logic [4:0] rd, rs, input logic [16:0] imm);
    return {5'b00101, rd, rs, imm};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive one word in an IDLE cycle and advance into READ.
  task automatic issue(input logic [31:0] insn);
    in_valid = 1'b1;
    in_insn  = insn;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    checks++; if (alu_opA !== 32'd0 || alu_opB !== 32'd0) begin errors++; $display("FAIL reset_alu_ops got=%h/%h exp=0/0", alu_opA, alu_opB); end
    checks++; if (rf_rs_addr !== 5'd0) begin errors++; $display("FAIL reset_rs_addr got=%0d exp=0", rf_rs_addr); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_add();
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    in_valid = 1'b1;
    in_insn  = r_insn(5'd3, 5'd1, 5'd2, 5'd0, 5'd0);
    #1;
    checks++; if (rf_rs_addr !== 5'd1 || rf_rt_addr !== 5'd2) begin errors++; $display("FAIL add_addr got=%0d/%0d exp=1/2", rf_rs_addr, rf_rt_addr); end
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL add_read_hs got=%b/%b exp=0/0", in_ready, wb_valid); end
    step();
    checks++; if (alu_opA !== 32'd5 || alu_opB !== 32'd7) begin errors++; $display("FAIL add_ops got=%h/%h exp=5/7", alu_opA, alu_opB); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_exec_wbv got=%b exp=0", wb_valid); end
    step();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_latency got=%b exp=1", wb_valid); end
    checks++; if (wb_rd !== 5'd3 || wb_data !== 32'd12) begin errors++; $display("FAIL add_wb got=%0d/%h exp=3/c", wb_rd, wb_data); end
    step();
    checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_done got=%b/%b exp=0/1", wb_valid, in_ready); end
  endtask

  task automatic test_overflow();
    regs[1] = 32'h8000_0000;
    regs[2] = 32'd1;
    issue(r_insn(5'd4, 5'd1, 5'd2, 5'd0, 5'd1));
    step(); step();
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd3) begin errors++; $display("FAIL sub_ovf got=%b/%0d/%h exp=1/30/3", wb_valid, wb_rd, wb_data); end
    step();
    regs[1] = 32'h7FFF_FFFF;
    issue(addi_insn(5'd7, 5'd1, 17'd1));
    step(); step();
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd2) begin errors++; $display("FAIL addi_ovf got=%b/%0d/%h exp=1/30/2", wb_valid, wb_rd, wb_data); end
    step();
    issue(r_insn(5'd0, 5'd1, 5'd1, 5'd0, 5'd0));
    step(); step();
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd1) begin errors++; $display("FAIL add_r0_ovf got=%b/%0d/%h exp=1/30/1", wb_valid, wb_rd, wb_data); end
    step();
  endtask

  task automatic test_addi_neg();
    issue(addi_insn(5'd5, 5'd0, 17'h1FFFF));
    step();
    checks++; if (alu_opB !== 32'hFFFF_FFFF || alu_opcode !== 5'd0) begin errors++; $display("FAIL addi_opB got=%h/%0d exp=ffffffff/0", alu_opB, alu_opcode); end
    step();
    checks++; if (wb_rd !== 5'd5 || wb_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_wb got=%0d/%h exp=5/ffffffff", wb_rd, wb_data); end
    step();
  endtask

  task automatic test_sra();
    regs[1] = 32'hF000_0000;
    issue(r_insn(5'd6, 5'd1, 5'd0, 5'd4, 5'd5));
    step();
    checks++; if (alu_opcode !== 5'd5 || alu_shamt !== 5'd4) begin errors++; $display("FAIL sra_ctl got=%0d/%0d exp=5/4", alu_opcode, alu_shamt); end
    step();
    checks++; if (wb_rd !== 5'd6 || wb_data !== 32'hFF00_0000) begin errors++; $display("FAIL sra_wb got=%0d/%h exp=6/ff000000", wb_rd, wb_data); end
    step();
  endtask

  task automatic test_stall();
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    wb_ready = 1'b0;
    issue(r_insn(5'd3, 5'd1, 5'd2, 5'd0, 5'd0));
    step(); step();
    in_valid = 1'b1;
    in_insn  = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd12) begin errors++; $display("FAIL stall_hold[%0d] got=%b/%0d/%h exp=1/3/c", i, wb_valid, wb_rd, wb_data); end
      checks++; if (in_ready !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got=%b/%b exp=0/0", i, in_ready, illegal); end
      step();
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", wb_valid); end
    step();
    checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_done got=%b/%b exp=0/1", wb_valid, in_ready); end
  endtask

  task automatic test_illegal();
    issue({5'b11111, 27'd0});
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_op got=%b exp=1", illegal); end
    step();
    checks++; if (illegal !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL illegal_end got=%b/%b exp=0/1", illegal, in_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL illegal_nowb[%0d] got=%b exp=0", i, wb_valid); end
      step();
    end
    issue(r_insn(5'd3, 5'd1, 5'd2, 5'd0, 5'd6));
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_aluop6 got=%b exp=1", illegal); end
    step();
    checks++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL aluop6_end got=%b/%b exp=1/0", in_ready, wb_valid); end
  endtask

  task automatic test_reset_exec();
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    issue(r_insn(5'd3, 5'd1, 5'd2, 5'd0, 5'd0));
    step();
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL rst_exec got=%b/%b exp=1/0", in_ready, wb_valid); end
    checks++; if (alu_opA !== 32'd0) begin errors++; $display("FAIL rst_exec_opA got=%h exp=0", alu_opA); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_nowb[%0d] got=%b exp=0", i, wb_valid); end
      step();
    end
  endtask

  task automatic test_rd0();
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    issue(r_insn(5'd0, 5'd1, 5'd2, 5'd0, 5'd0));
    step();
    step();
    checks++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL rd0_skip got=%b/%b exp=1/0", in_ready, wb_valid); end
    step();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rd0_nowb got=%b exp=0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    issue(r_insn(5'd9, 5'd1, 5'd2, 5'd0, 5'd1));
    step(); step();
    checks++; if (wb_rd !== 5'd9 || wb_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_first got=%0d/%h exp=9/fffffffe", wb_rd, wb_data); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    issue(r_insn(5'd8, 5'd1, 5'd2, 5'd0, 5'd3));
    step(); step();
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 32'd7) begin errors++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/8/7", wb_valid, wb_rd, wb_data); end
    step();
    issue(r_insn(5'd10, 5'd1, 5'd2, 5'd0, 5'd2));
    step(); step();
    checks++; if (wb_rd !== 5'd10 || wb_data !== 32'd5) begin errors++; $display("FAIL b2b_and got=%0d/%h exp=10/5", wb_rd, wb_data); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_insn  = 32'd0;
    wb_ready = 1'b1;
    test_reset();
    test_add();
    test_overflow();
    test_addi_neg();
    test_sra();
    test_stall();
    test_illegal();
    test_reset_exec();
    test_rd0();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
